veri_onbellegi_nyol: RTL

Parametrised N-way set-associative, write-back, write-allocate L1 data cache. Sits between the core's memory stage (l1v_* port) and the main-memory controller (iomem_* port). Generalises the two-way data cache to configurable address width, set count and associativity. Adds per-set round-robin replacement, arbitrary byte masks, a full-word-write fetch bypass and a flush (dirty write-back) command.

---
 rtl/veri_onbellegi_nyol_if.sv | 35 +++
 rtl/veri_onbellegi_nyol.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/veri_onbellegi_nyol_if.sv
// Core-side (l1v_*) and memory-side (iomem_*) signals of the L1 data cache.
// The cache takes the slave view; the core/memory environment takes the master view.
interface veri_onbellegi_nyol_if #(
   parameter int ADR_W = 19
);
   logic             l1v_sec_i;
   logic [ADR_W-1:2] l1v_adr_i;
   logic [31:0]      l1v_veri_i;
   logic [3:0]       l1v_veri_maske_i;
   logic [31:0]      l1v_veri_o;
   logic             l1v_durdur_o;
   logic             l1v_bosalt_i;
   logic             l1v_bosalt_bitti_o;

   logic [ADR_W-1:2] iomem_addr_o;
   logic             iomem_valid_o;
   logic [31:0]      iomem_wdata_o;
   logic [3:0]       iomem_wstrb_o;
   logic [31:0]      iomem_rdata_i;
   logic             iomem_ready_i;

   modport slave (
      input  l1v_sec_i, l1v_adr_i, l1v_veri_i, l1v_veri_maske_i, l1v_bosalt_i,
      input  iomem_rdata_i, iomem_ready_i,
      output l1v_veri_o, l1v_durdur_o, l1v_bosalt_bitti_o,
      output iomem_addr_o, iomem_valid_o, iomem_wdata_o, iomem_wstrb_o
   );

   modport master (
      output l1v_sec_i, l1v_adr_i, l1v_veri_i, l1v_veri_maske_i, l1v_bosalt_i,
      output iomem_rdata_i, iomem_ready_i,
      input  l1v_veri_o, l1v_durdur_o, l1v_bosalt_bitti_o,
      input  iomem_addr_o, iomem_valid_o, iomem_wdata_o, iomem_wstrb_o
   );
endinterface

// File: rtl/veri_onbellegi_nyol.sv
// N-way set-associative, write-back, write-allocate L1 data cache with one word per line,
// per-set round-robin replacement, masked stores and a dirty-line flush command.
module veri_onbellegi_nyol #(
   parameter int ADR_W = 19,
   parameter int SET_W = 8,
   parameter int WAY_W = 1
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   veri_onbellegi_nyol_if.slave bus
);
   localparam int TAG_W = ADR_W - 2 - SET_W;
   localparam int SETS  = 1 << SET_W;
   localparam int WAYS  = 1 << WAY_W;
   localparam int PW    = (WAY_W > 0) ? WAY_W : 1;

   typedef enum logic [3:0] {
      BEKLE,
      ARA,
      GERI_YAZ,
      DOLDUR,
      YERLES,
      BITTI,
      BOSALT,
      BOSALT_BAK,
      BOSALT_YAZ
   } durum_t;

   durum_t durum, durum_nxt;

   logic [TAG_W-1:0] tag_mem  [WAYS][SETS];
   logic [31:0]      data_mem [WAYS][SETS];
   logic [WAYS-1:0]  valid_q  [SETS];
   logic [WAYS-1:0]  dirty_q  [SETS];
   logic [PW-1:0]    ptr_q    [SETS];

   logic [TAG_W-1:0] rd_tag  [WAYS];
   logic [31:0]      rd_data [WAYS];

   logic [SET_W-1:0] idx;
   logic [SET_W-1:0] oku_idx;
   logic [SET_W-1:0] bos_set;
   logic [TAG_W-1:0] tag;
   logic [PW-1:0]    bos_way;
   logic [PW-1:0]    victim_q;
   logic [PW-1:0]    vict;
   logic [PW-1:0]    hit_way;
   logic             hit;
   logic             vict_kirli;
   logic             bos_kirli;
   logic             bos_son;
   logic             io_ack;
   logic             tam_yazma;
   logic             yukleme;
   logic [31:0]      hit_data;
   logic [31:0]      yerles_veri;
   logic [31:0]      doldur_q;

   logic             iomem_valid_q;
   logic [ADR_W-1:2] iomem_addr_q;
   logic [31:0]      iomem_wdata_q;
   logic [3:0]       iomem_wstrb_q;
   logic [31:0]      veri_q;
   logic             bitti_q;

   function automatic logic [31:0] birlestir(input logic [31:0] eski,
                                             input logic [31:0] yeni,
                                             input logic [3:0]  maske);
      logic [31:0] sonuc;
      sonuc = eski;
      for (int b = 0; b < 4; b++) begin
         if (maske[b]) sonuc[8*b +: 8] = yeni[8*b +: 8];
      end
      return sonuc;
   endfunction

   assign idx       = bus.l1v_adr_i[SET_W+1:2];
   assign tag       = bus.l1v_adr_i[ADR_W-1:SET_W+2];
   assign tam_yazma = (bus.l1v_veri_maske_i == 4'b1111);
   assign yukleme   = (bus.l1v_veri_maske_i == 4'b0000);
   assign io_ack    = iomem_valid_q & bus.iomem_ready_i;
   assign oku_idx   = (durum == BOSALT) ? bos_set : idx;

   // Lookup, victim choice and flush-walk status, all combinational over the registered reads.
   always_comb begin
      // NOTE: every output of this block gets a default first, so no path can infer a latch.
      hit         = 1'b0;
      hit_way     = '0;
      vict        = ptr_q[idx];
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (!valid_q[idx][w]) vict = PW'(w);
      end
      for (int w = 0; w < WAYS; w++) begin
         if (valid_q[idx][w] && (rd_tag[w] == tag)) begin
            hit     = 1'b1;
            hit_way = PW'(w);
         end
      end
      hit_data    = rd_data[hit_way];
      vict_kirli  = valid_q[idx][vict] & dirty_q[idx][vict];
      yerles_veri = birlestir(doldur_q, bus.l1v_veri_i, bus.l1v_veri_maske_i);
      bos_kirli   = valid_q[bos_set][bos_way] & dirty_q[bos_set][bos_way];
      bos_son     = (bos_set == '1) && (bos_way == PW'(WAYS - 1));
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      // NOTE: sequential state is updated with non-blocking assignments only.
      if (rst_i) durum <= BEKLE;
      else       durum <= durum_nxt;
   end

   always_comb begin
      durum_nxt = durum;
      case (durum)
         BEKLE: begin
            if (bus.l1v_bosalt_i)   durum_nxt = BOSALT;
            else if (bus.l1v_sec_i) durum_nxt = ARA;
         end
         ARA: begin
            if (hit)             durum_nxt = BITTI;
            else if (vict_kirli) durum_nxt = GERI_YAZ;
            else if (tam_yazma)  durum_nxt = YERLES;
            else                 durum_nxt = DOLDUR;
         end
         GERI_YAZ:   if (io_ack) durum_nxt = tam_yazma ? YERLES : DOLDUR;
         DOLDUR:     if (io_ack) durum_nxt = YERLES;
         YERLES:     durum_nxt = BITTI;
         BITTI:      durum_nxt = BEKLE;
         BOSALT:     durum_nxt = BOSALT_BAK;
         BOSALT_BAK: begin
            if (bos_kirli)    durum_nxt = BOSALT_YAZ;
            else if (bos_son) durum_nxt = BEKLE;
            else              durum_nxt = BOSALT;
         end
         BOSALT_YAZ: if (io_ack) durum_nxt = bos_son ? BEKLE : BOSALT;
         default:    durum_nxt = BEKLE;
      endcase
   end

   // Control state: line status bits, replacement pointers, memory request and flush walk.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int s = 0; s < SETS; s++) begin
            valid_q[s] <= '0;
            dirty_q[s] <= '0;
            ptr_q[s]   <= '0;
         end
         iomem_valid_q <= 1'b0;
         iomem_addr_q  <= '0;
         iomem_wdata_q <= '0;
         iomem_wstrb_q <= '0;
         veri_q        <= '0;
         bitti_q       <= 1'b0;
         victim_q      <= '0;
         doldur_q      <= '0;
         bos_set       <= '0;
         bos_way       <= '0;
      end else begin
         bitti_q <= 1'b0;
         case (durum)
            BEKLE: begin
               if (bus.l1v_bosalt_i) begin
                  bos_set <= '0;
                  bos_way <= '0;
               end
            end
            ARA: begin
               victim_q <= vict;
               if (hit) begin
                  if (yukleme) veri_q <= hit_data;
                  else         dirty_q[idx][hit_way] <= 1'b1;
               end else if (vict_kirli) begin
                  iomem_valid_q <= 1'b1;
                  iomem_addr_q  <= {rd_tag[vict], idx};
                  iomem_wdata_q <= rd_data[vict];
                  iomem_wstrb_q <= 4'b1111;
               end else if (!tam_yazma) begin
                  iomem_valid_q <= 1'b1;
                  iomem_addr_q  <= bus.l1v_adr_i;
                  iomem_wdata_q <= '0;
                  iomem_wstrb_q <= 4'b0000;
               end
            end
            GERI_YAZ: if (io_ack) iomem_valid_q <= 1'b0;
            DOLDUR: begin
               // Arriving from a write-back the bus is idle for a cycle before the fetch goes out.
               if (!iomem_valid_q) begin
                  iomem_valid_q <= 1'b1;
                  iomem_addr_q  <= bus.l1v_adr_i;
                  iomem_wdata_q <= '0;
                  iomem_wstrb_q <= 4'b0000;
               end else if (bus.iomem_ready_i) begin
                  iomem_valid_q <= 1'b0;
                  doldur_q      <= bus.iomem_rdata_i;
               end
            end
            YERLES: begin
               valid_q[idx][victim_q] <= 1'b1;
               dirty_q[idx][victim_q] <= !yukleme;
               ptr_q[idx]             <= (WAYS == 1) ? '0 : victim_q + 1'b1;
               veri_q                 <= yerles_veri;
            end
            BOSALT_BAK: begin
               if (bos_kirli) begin
                  iomem_valid_q <= 1'b1;
                  iomem_addr_q  <= {rd_tag[bos_way], bos_set};
                  iomem_wdata_q <= rd_data[bos_way];
                  iomem_wstrb_q <= 4'b1111;
               end else if (bos_son) begin
                  bitti_q <= 1'b1;
               end else begin
                  bos_way <= (bos_way == PW'(WAYS - 1)) ? '0 : bos_way + 1'b1;
                  if (bos_way == PW'(WAYS - 1)) bos_set <= bos_set + 1'b1;
               end
            end
            BOSALT_YAZ: begin
               if (io_ack) begin
                  iomem_valid_q              <= 1'b0;
                  dirty_q[bos_set][bos_way]  <= 1'b0;
                  if (bos_son) begin
                     bitti_q <= 1'b1;
                  end else begin
                     bos_way <= (bos_way == PW'(WAYS - 1)) ? '0 : bos_way + 1'b1;
                     if (bos_way == PW'(WAYS - 1)) bos_set <= bos_set + 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   // NOTE: tag/data arrays carry no reset; the valid bits gate every use of their contents.
   always_ff @(posedge clk_i) begin
      if (durum == BEKLE || durum == BOSALT) begin
         for (int w = 0; w < WAYS; w++) begin
            rd_tag[w]  <= tag_mem[w][oku_idx];
            rd_data[w] <= data_mem[w][oku_idx];
         end
      end
      if (durum == ARA && hit && !yukleme) begin
         data_mem[hit_way][idx] <= birlestir(hit_data, bus.l1v_veri_i, bus.l1v_veri_maske_i);
      end
      if (durum == YERLES) begin
         tag_mem[victim_q][idx]  <= tag;
         data_mem[victim_q][idx] <= yerles_veri;
      end
   end

   assign bus.l1v_veri_o         = veri_q;
   assign bus.l1v_durdur_o       = bus.l1v_sec_i & (durum != BITTI);
   assign bus.l1v_bosalt_bitti_o = bitti_q;
   assign bus.iomem_valid_o      = iomem_valid_q;
   assign bus.iomem_addr_o       = iomem_addr_q;
   assign bus.iomem_wdata_o      = iomem_wdata_q;
   assign bus.iomem_wstrb_o      = iomem_wstrb_q;
endmodule
